// File: rtl/pic_host_initiator.sv
// 8259 host initiator: ICW1..ICW4 init writes, then 8086-style two-pulse INTA with vector handoff (PIC_INIT_OCW1_EN adds an OCW1 mask write).
// Strobes start the cycle after a request is seen in IDLE; a captured vector is held on vec_valid until vec_ready.
module pic_host_initiator #(
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
`ifdef PIC_INIT_OCW1_EN
  input  logic [7:0] ocw1_mask,
`endif
  input  logic       init_start,
  output logic       init_busy,
  output logic       init_done,
  input  logic       intr,
  output logic       inta_n,
  output logic       wr_n,
  output logic       cs_n,
  output logic       a0,
  output logic [7:0] data_out,
  input  logic [7:0] data_in,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  input  logic       vec_ready
);

  typedef enum logic [2:0] {IDLE, WR_STB, WR_GAP, INTA1, GAP1, INTA2, GAP2, VEC_OUT} state_t;

  localparam logic [15:0] PULSE_LD = 16'(PULSE_CYC - 1);
  localparam logic [15:0] GAP_LD   = 16'(GAP_CYC - 1);

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [2:0]      nw_q, nw_d;
  logic [4:0][7:0] list_q, list_d;
  logic            inta_n_q, inta_n_d;
  logic            wr_n_q, wr_n_d;
  logic            a0_q, a0_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            vec_valid_q, vec_valid_d;
  logic [7:0]      vec_data_q, vec_data_d;
  logic            cnt_last;
  logic [2:0]      n;

  assign cnt_last = (cnt_q == 16'd0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_last ? cnt_q : cnt_q - 16'd1;
    idx_d       = idx_q;
    nw_d        = nw_q;
    list_d      = list_q;
    inta_n_d    = 1'b1;
    wr_n_d      = 1'b1;
    a0_d        = a0_q;
    data_out_d  = data_out_q;
    busy_d      = busy_q;
    done_d      = done_q;
    vec_valid_d = vec_valid_q;
    vec_data_d  = vec_data_q;
    n           = 3'd2;

    case (state_q)
      IDLE: begin
        if (init_start) begin
          // Word list is frozen here so later icw* changes cannot disturb a running init.
          list_d    = '0;
          list_d[0] = icw1;
          list_d[1] = icw2;
          if (!icw1[1]) begin
            list_d[n] = icw3;
            n         = n + 3'd1;
          end
          if (icw1[0]) begin
            list_d[n] = icw4;
            n         = n + 3'd1;
          end
`ifdef PIC_INIT_OCW1_EN
          list_d[n] = ocw1_mask;
          n         = n + 3'd1;
`endif
          nw_d       = n;
          idx_d      = 3'd0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          wr_n_d     = 1'b0;
          a0_d       = 1'b0;
          data_out_d = icw1;
          cnt_d      = PULSE_LD;
          state_d    = WR_STB;
        end else if (intr && done_q) begin
          inta_n_d = 1'b0;
          cnt_d    = PULSE_LD;
          state_d  = INTA1;
        end
      end
      WR_STB: begin
        if (cnt_last) begin
          cnt_d   = GAP_LD;
          state_d = WR_GAP;
        end else begin
          wr_n_d = 1'b0;
        end
      end
      WR_GAP: begin
        if (cnt_last) begin
          if (idx_q == nw_q - 3'd1) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d      = idx_q + 3'd1;
            wr_n_d     = 1'b0;
            a0_d       = 1'b1;
            data_out_d = list_q[idx_q + 3'd1];
            cnt_d      = PULSE_LD;
            state_d    = WR_STB;
          end
        end
      end
      INTA1: begin
        if (cnt_last) begin
          cnt_d   = GAP_LD;
          state_d = GAP1;
        end else begin
          inta_n_d = 1'b0;
        end
      end
      GAP1: begin
        if (cnt_last) begin
          inta_n_d = 1'b0;
          cnt_d    = PULSE_LD;
          state_d  = INTA2;
        end
      end
      INTA2: begin
        if (cnt_last) begin
          vec_data_d = data_in;
          cnt_d      = GAP_LD;
          state_d    = GAP2;
        end else begin
          inta_n_d = 1'b0;
        end
      end
      GAP2: begin
        if (cnt_last) begin
          vec_valid_d = 1'b1;
          state_d     = VEC_OUT;
        end
      end
      VEC_OUT: begin
        if (vec_valid_q && vec_ready) begin
          vec_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      nw_q        <= '0;
      list_q      <= '0;
      inta_n_q    <= 1'b1;
      wr_n_q      <= 1'b1;
      a0_q        <= 1'b0;
      data_out_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vec_valid_q <= 1'b0;
      vec_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      nw_q        <= nw_d;
      list_q      <= list_d;
      inta_n_q    <= inta_n_d;
      wr_n_q      <= wr_n_d;
      a0_q        <= a0_d;
      data_out_q  <= data_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      vec_valid_q <= vec_valid_d;
      vec_data_q  <= vec_data_d;
    end
  end

  assign inta_n    = inta_n_q;
  assign wr_n      = wr_n_q;
  assign cs_n      = wr_n_q;
  assign a0        = a0_q;
  assign data_out  = data_out_q;
  assign init_busy = busy_q;
  assign init_done = done_q;
  assign vec_valid = vec_valid_q;
  assign vec_data  = vec_data_q;

endmodule
